// File: rtl/burst_input_buffer_pkg.sv
// Shared types for the burst input buffer: FSM encoding and beat-count helper.
package burst_input_buffer_pkg;

    typedef enum logic [1:0] {
        INBUF_IDLE,
        INBUF_ISSUE,
        INBUF_WAIT,
        INBUF_FLUSH
    } inbuf_state_t;

    function automatic logic [31:0] ceil_div(
        input logic [31:0] n,
        input logic [31:0] d
    );
        return (n + d - 32'd1) / d;
    endfunction

endpackage

// File: rtl/burst_input_buffer_if.sv
// Read-master side of the burst input buffer: burst request and beat return.
interface burst_input_buffer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
);
    logic                  rmst_req;
    logic [ADDR_WIDTH-1:0] addr_offset;
    logic [63:0]           xfer_size;
    logic                  rmst_done;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  valid;
    logic                  ready;

    modport master (
        output rmst_req, addr_offset, xfer_size, ready,
        input  rmst_done, tdata, valid
    );

    modport slave (
        input  rmst_req, addr_offset, xfer_size, ready,
        output rmst_done, tdata, valid
    );
endinterface

// File: rtl/burst_input_buffer_fifo.sv
// Register-array FIFO with synchronous clear and occupancy count.
module FifoType0 #(
    parameter int data_width = 512,
    parameter int addr_bits  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CLEAR,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [addr_bits:0]    DATA_CNT
);
    localparam int DEPTH = 2 ** addr_bits;
    localparam logic [addr_bits:0]   CNT_ONE = 1;
    localparam logic [addr_bits-1:0] PTR_ONE = 1;

    logic [data_width-1:0] mem [DEPTH];
    logic [addr_bits-1:0]  wr_ptr;
    logic [addr_bits-1:0]  rd_ptr;
    logic [addr_bits:0]    cnt;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (addr_bits+1)'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign DATA_CNT = cnt;
    assign dout     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/burst_input_buffer.sv
// Burst-splitting, credit-gated input staging buffer for the conv read path.
// Define INBUF_BYPASS_EN for a zero-latency empty-FIFO bypass on o_data.
module burst_input_buffer
    import burst_input_buffer_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int FIFO_ADDR_WIDTH = 7,
    parameter int BURST_LENGTH    = 64,
    parameter int ADDR_WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_start,
    input  logic                  end_conv,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    input  logic [31:0]           input_byte,
    burst_input_buffer_if.master  rmst,
    input  logic                  pop_req,
    input  logic                  g_stall,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_v,
    output logic                  stall,
    output logic                  busy,
    output logic                  job_done
);
    localparam int DW_BYTE     = DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LENGTH * DW_BYTE;
    localparam int DEPTH       = 2 ** FIFO_ADDR_WIDTH;
    localparam int CW          = FIFO_ADDR_WIDTH + 2;
    localparam logic [CW-1:0] C_ONE = 1;

    inbuf_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [31:0]              remain;
    logic [31:0]              size;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            out_nxt;
    logic [CW-1:0]            beats;
    logic [CW-1:0]            free;
    logic [FIFO_ADDR_WIDTH:0] data_cnt;
    logic [DATA_WIDTH-1:0]    fifo_dout;
    logic in_flight, alive, sinking, issue, finish;
    logic fifo_empty, fifo_full, clear;
    logic push_acc, push_fifo, pop_fire, pop_fifo;

    assign size  = (remain < 32'(BURST_BYTES)) ? remain : 32'(BURST_BYTES);
    assign beats = CW'(ceil_div(size, 32'(DW_BYTE)));
    assign free  = CW'(DEPTH) - CW'(data_cnt) - outstanding;

    // IDLE and FLUSH swallow stray beats so the read master never blocks.
    assign sinking  = (state == INBUF_IDLE) | (state == INBUF_FLUSH);
    assign push_acc = rmst.valid & rmst.ready & ~sinking & ~end_conv;
    assign issue    = (state == INBUF_ISSUE) & ~end_conv & (free >= beats);
    assign clear    = end_conv | (state == INBUF_FLUSH);

    assign rmst.ready       = alive & (sinking | ~fifo_full);
    assign rmst.rmst_req    = issue;
    assign rmst.addr_offset = cur_addr;
    assign rmst.xfer_size   = 64'(size);

    assign busy  = (state != INBUF_IDLE);
    assign stall = ~o_data_v;

`ifdef INBUF_BYPASS_EN
    logic bypass;
    assign bypass    = push_acc & fifo_empty;
    assign o_data_v  = ~fifo_empty | bypass;
    assign o_data    = bypass ? rmst.tdata : fifo_dout;
    assign pop_fire  = pop_req & ~g_stall & o_data_v;
    assign push_fifo = push_acc & ~(bypass & pop_fire);
    assign pop_fifo  = pop_fire & ~fifo_empty;
`else
    assign o_data_v  = ~fifo_empty;
    assign o_data    = fifo_dout;
    assign pop_fire  = pop_req & ~g_stall & o_data_v;
    assign push_fifo = push_acc;
    assign pop_fifo  = pop_fire;
`endif

    always_comb begin
        out_nxt = outstanding;
        if (issue) out_nxt = out_nxt + beats;
        if (push_acc && outstanding != '0) out_nxt = out_nxt - C_ONE;
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        if (end_conv) begin
            state_nxt = INBUF_FLUSH;
        end else begin
            unique case (state)
                INBUF_IDLE: begin
                    if (op_start) begin
                        if (input_byte != '0) state_nxt = INBUF_ISSUE;
                        else                  finish    = 1'b1;
                    end
                end
                INBUF_ISSUE: begin
                    if (issue) state_nxt = INBUF_WAIT;
                end
                INBUF_WAIT: begin
                    // Last burst: hold job_done until every beat has landed.
                    if (rmst.rmst_done) begin
                        if (remain != size) begin
                            state_nxt = INBUF_ISSUE;
                        end else if (out_nxt == '0) begin
                            state_nxt = INBUF_IDLE;
                            finish    = 1'b1;
                        end
                    end else if (!in_flight && out_nxt == '0) begin
                        state_nxt = INBUF_IDLE;
                        finish    = 1'b1;
                    end
                end
                INBUF_FLUSH: begin
                    if (!in_flight || rmst.rmst_done) state_nxt = INBUF_IDLE;
                end
                default: state_nxt = INBUF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INBUF_IDLE;
            cur_addr    <= '0;
            remain      <= '0;
            outstanding <= '0;
            in_flight   <= 1'b0;
            alive       <= 1'b0;
            job_done    <= 1'b0;
        end else begin
            alive       <= 1'b1;
            state       <= state_nxt;
            job_done    <= finish;
            outstanding <= (state == INBUF_FLUSH) ? '0 : out_nxt;
            if (issue)               in_flight <= 1'b1;
            else if (rmst.rmst_done) in_flight <= 1'b0;
            if (state == INBUF_IDLE && op_start && !end_conv
                && input_byte != '0) begin
                cur_addr <= addr_base;
                remain   <= input_byte;
            end
            if (state == INBUF_WAIT && rmst.rmst_done && !end_conv) begin
                cur_addr <= cur_addr + ADDR_WIDTH'(size);
                remain   <= remain - size;
            end
            if (state == INBUF_FLUSH && state_nxt == INBUF_IDLE)
                remain <= '0;
        end
    end

    FifoType0 #(
        .data_width (DATA_WIDTH),
        .addr_bits  (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .CLEAR    (clear),
        .push     (push_fifo),
        .pop      (pop_fifo),
        .din      (rmst.tdata),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .DATA_CNT (data_cnt)
    );
endmodule

// File: tb/tb_burst_input_buffer.sv
// Directed bench for burst_input_buffer with a cycle-stepped read master and consumer.
module tb_burst_input_buffer;
    localparam int DW = 512;
    localparam int AW = 64;
`ifdef INBUF_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_start = 1'b0;
    logic          end_conv = 1'b0;
    logic [AW-1:0] addr_base = '0;
    logic [31:0]   input_byte = '0;
    logic          pop_req = 1'b0;
    logic          g_stall = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_data_v, stall, busy, job_done;

    burst_input_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rmst ();

    burst_input_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_start   (op_start),
        .end_conv   (end_conv),
        .addr_base  (addr_base),
        .input_byte (input_byte),
        .rmst       (rmst),
        .pop_req    (pop_req),
        .g_stall    (g_stall),
        .o_data     (o_data),
        .o_data_v   (o_data_v),
        .stall      (stall),
        .busy       (busy),
        .job_done   (job_done)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, cyc = 0;
    int sl_state, sl_left, push_cnt, pop_cnt, req_cnt, done_cnt, pop_lim;
    int push_cyc, ov_cyc, rdone_cyc, rdone_first, done_push, start_cyc;
    bit pop_on = 1'b0, rnd = 1'b0;
    logic [31:0] data_seq, exp_seq;
    logic [63:0] req_addr [4];
    logic [63:0] req_size [4];
    int          req_cyc  [4];
    int          req_pops [4];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        sl_state = 0; sl_left = 0; data_seq = '0; exp_seq = '0;
        push_cnt = 0; pop_cnt = 0; req_cnt = 0; done_cnt = 0;
        push_cyc = -1; ov_cyc = -1; rdone_cyc = -1; rdone_first = -1;
        done_push = -1;
    endtask

    task automatic step();
        @(negedge clk);
        if (rmst.valid) chk("ready_when_valid", 64'(rmst.ready), 64'd1);
        if (sl_state == 2) begin
            rdone_cyc = cyc;
            if (rdone_first < 0) rdone_first = cyc;
            sl_state = 0;
        end else if (sl_state == 1) begin
            if (rmst.valid && rmst.ready) begin
                if (push_cyc < 0) push_cyc = cyc;
                push_cnt++;
                data_seq++;
                sl_left--;
                if (sl_left == 0) sl_state = 2;
            end
        end else if (rmst.rmst_req) begin
            if (req_cnt < 4) begin
                req_addr[req_cnt] = rmst.addr_offset;
                req_size[req_cnt] = rmst.xfer_size;
                req_cyc[req_cnt]  = cyc;
                req_pops[req_cnt] = pop_cnt;
            end
            req_cnt++;
            sl_left  = int'((rmst.xfer_size + 64'd63) / 64'd64);
            sl_state = (sl_left > 0) ? 1 : 2;
        end
        if (pop_req && !g_stall && o_data_v) begin
            chk_d("pop_order", o_data, {16{exp_seq}});
            exp_seq++;
            pop_cnt++;
        end
        if (o_data_v && ov_cyc < 0) ov_cyc = cyc;
        if (job_done) begin
            done_cnt++;
            done_push = push_cnt;
        end
        @(posedge clk);
        #1;
        cyc++;
        rmst.valid     = (sl_state == 1);
        rmst.tdata     = {16{data_seq}};
        rmst.rmst_done = (sl_state == 2);
        pop_req = pop_on && (pop_cnt < pop_lim)
                  && (!rnd || $urandom_range(0, 1) == 1);
        g_stall = rnd && ($urandom_range(0, 3) == 0);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_done(int lim, string tag);
        int k = 0;
        while (done_cnt == 0 && k < lim) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic drain(int n, int lim, string tag);
        int k = 0;
        while (pop_cnt < n && k < lim) begin
            step();
            k++;
        end
        chk({tag, "_pops"}, 64'(pop_cnt), 64'(n));
    endtask

    task automatic start_job(logic [AW-1:0] a, logic [31:0] b);
        addr_base  = a;
        input_byte = b;
        op_start   = 1'b1;
        start_cyc  = cyc;
        step();
        op_start   = 1'b0;
    endtask

    initial begin
        int k;
        rmst.valid = 1'b0;
        rmst.tdata = '0;
        rmst.rmst_done = 1'b0;
        pop_lim = 0;
        clr();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rmst_req", 64'(rmst.rmst_req), 64'd0);
        chk("rst_addr_offset", rmst.addr_offset, 64'd0);
        chk("rst_xfer_size", rmst.xfer_size, 64'd0);
        chk("rst_ready", 64'(rmst.ready), 64'd0);
        chk_d("rst_o_data", o_data, '0);
        chk("rst_o_data_v", 64'(o_data_v), 64'd0);
        chk("rst_stall", 64'(stall), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2);

        clr();
        pop_on = 1'b1;
        pop_lim = 1000000;
        start_job(64'h500, 32'd0);
        step();
        chk("zero_done", 64'(done_cnt), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        run(2);
        chk("zero_done_once", 64'(done_cnt), 64'd1);
        chk("zero_req", 64'(req_cnt), 64'd0);

        clr();
        start_job(64'h40, 32'd1);
        wait_done(100, "one");
        run(3);
        chk("one_req", 64'(req_cnt), 64'd1);
        chk("one_addr", req_addr[0], 64'h40);
        chk("one_size", req_size[0], 64'd1);
        chk("one_req_lat", 64'(req_cyc[0] - start_cyc), 64'd1);
        chk("one_push", 64'(push_cnt), 64'd1);
        chk("one_pop", 64'(pop_cnt), 64'd1);
        chk("one_v_lat", 64'(ov_cyc - push_cyc), 64'(LAT));
        chk("one_stall", 64'(stall), 64'd1);

        clr();
        start_job(64'h1000, 32'd10000);
        wait_done(1000, "multi");
        chk("multi_req", 64'(req_cnt), 64'd3);
        chk("multi_addr0", req_addr[0], 64'h1000);
        chk("multi_addr1", req_addr[1], 64'h2000);
        chk("multi_addr2", req_addr[2], 64'h3000);
        chk("multi_size0", req_size[0], 64'd4096);
        chk("multi_size1", req_size[1], 64'd4096);
        chk("multi_size2", req_size[2], 64'd1808);
        chk("multi_done_push", 64'(done_push), 64'd157);
        chk("multi_gap", 64'(req_cyc[1] - rdone_first), 64'd1);
        chk("multi_busy", 64'(busy), 64'd0);
        drain(157, 50, "multi");

        clr();
        pop_lim = 0;
        start_job(64'h0, 32'd12288);
        run(250);
        chk("credit_req2", 64'(req_cnt), 64'd2);
        chk("credit_push", 64'(push_cnt), 64'd128);
        chk("credit_full_v", 64'(o_data_v), 64'd1);
        chk("credit_full_rdy", 64'(rmst.ready), 64'd0);
        start_job(64'h9000, 32'd64);
        run(5);
        chk("busy_op_ignored", 64'(req_cnt), 64'd2);
        pop_lim = 63;
        run(120);
        chk("credit_hold_req", 64'(req_cnt), 64'd2);
        chk("credit_hold_pop", 64'(pop_cnt), 64'd63);
        pop_lim = 64;
        run(6);
        chk("credit_req3", 64'(req_cnt), 64'd3);
        chk("credit_req3_pops", 64'(req_pops[2]), 64'd64);
        pop_lim = 1000000;
        wait_done(1000, "credit");
        chk("credit_addr2", req_addr[2], 64'h2000);
        chk("credit_done_push", 64'(done_push), 64'd192);
        drain(192, 300, "credit");

        clr();
        rnd = 1'b1;
        start_job(64'h0, 32'd8192);
        wait_done(2000, "rand");
        drain(128, 2000, "rand");
        rnd = 1'b0;
        chk("rand_req", 64'(req_cnt), 64'd2);

        clr();
        pop_lim = 0;
        start_job(64'h0, 32'd8192);
        k = 0;
        while (push_cnt < 10 && k < 100) begin
            step();
            k++;
        end
        end_conv   = 1'b1;
        op_start   = 1'b1;
        addr_base  = 64'h7000;
        input_byte = 32'd4096;
        step();
        end_conv = 1'b0;
        op_start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_stall", 64'(stall), 64'd1);
        chk("abort_v", 64'(o_data_v), 64'd0);
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_idle_lat", 64'(cyc - rdone_cyc), 64'd1);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_sunk", 64'(push_cnt), 64'd64);
        chk("abort_req", 64'(req_cnt), 64'd1);
        run(3);
        chk("abort_stay_idle", 64'(busy), 64'd0);
        chk("abort_stall_end", 64'(stall), 64'd1);

        clr();
        pop_lim = 1000000;
        start_job(64'h0, 32'd8192);
        k = 0;
        while (push_cnt < 5 && k < 100) begin
            step();
            k++;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_ready", 64'(rmst.ready), 64'd0);
        chk("mrst_v", 64'(o_data_v), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd1);
        chk("mrst_req", 64'(rmst.rmst_req), 64'd0);
        chk("mrst_size", rmst.xfer_size, 64'd0);
        sl_state = 0;
        rmst.valid = 1'b0;
        rmst.rmst_done = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2);
        chk("mrst_after", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
